elevator_request_scheduler: RTL and testbench

Call-button front end that drives the elevator controller's `request_floor` input. It latches hall/car calls for the three floors and serves them in SCAN order, preferring to keep the current direction. Each request is held stable until the controller reports arrival (matching `current_floor` and idle `elevator_status`). After arrival it clears the served call and holds a door-open dwell before dispatching the next call.

---
 rtl/elevator_pkg.sv | 36 +++
 rtl/elevator_request_scheduler_if.sv | 33 +++
 rtl/door_dwell_timer.sv | 36 +++
 rtl/elevator_request_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_elevator_request_scheduler.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/elevator_pkg.sv
// Shared constants for the elevator controller and its call scheduler.
// Floor and status encodings match the controller's wire format.
package elevator_pkg;

    localparam logic [1:0] FLOOR_1   = 2'b00;
    localparam logic [1:0] FLOOR_2   = 2'b01;
    localparam logic [1:0] FLOOR_3   = 2'b10;
    localparam logic [1:0] FLOOR_BAD = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_UP   = 2'b01;
    localparam logic [1:0] ST_DOWN = 2'b10;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef enum logic [1:0] {
        SCHED_IDLE     = 2'd0,
        SCHED_DISPATCH = 2'd1,
        SCHED_DWELL    = 2'd2
    } sched_state_e;

    // One-hot floor mask; the invalid code maps to no floor.
    function automatic logic [2:0] floor_onehot(input logic [1:0] f);
        logic [2:0] m;
        m = 3'b000;
        unique case (f)
            FLOOR_1: m = 3'b001;
            FLOOR_2: m = 3'b010;
            FLOOR_3: m = 3'b100;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/elevator_request_scheduler_if.sv
// Bundle between the call-button scheduler and the elevator controller side.
// master drives calls and controller feedback; slave is the scheduler.
interface elevator_request_scheduler_if;

    logic [2:0] call_btn;
    logic [1:0] current_floor;
    logic [1:0] elevator_status;
    logic [1:0] request_floor;
    logic       req_active;
    logic [2:0] pending;
    logic       door_open;

    modport master (
        output call_btn,
        output current_floor,
        output elevator_status,
        input  request_floor,
        input  req_active,
        input  pending,
        input  door_open
    );

    modport slave (
        input  call_btn,
        input  current_floor,
        input  elevator_status,
        output request_floor,
        output req_active,
        output pending,
        output door_open
    );

endinterface

// File: rtl/door_dwell_timer.sv
// Door-open dwell down-counter with load/reload.
// done_o is high while the count sits at zero.
module door_dwell_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       en_i,
    output logic       done_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Reload wins over decrement; count saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == 8'd0);

endmodule

// File: rtl/elevator_request_scheduler.sv
// Three-floor call latch and SCAN-order request scheduler.
// Holds each request until arrival, then dwells with the door open.
module elevator_request_scheduler
    import elevator_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    elevator_request_scheduler_if.slave  bus
);

    localparam logic [1:0] IDLE     = SCHED_IDLE;
    localparam logic [1:0] DISPATCH = SCHED_DISPATCH;
    localparam logic [1:0] DWELL    = SCHED_DWELL;

    localparam logic [7:0] DWELL_LOAD = 8'(DWELL_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic       dir_q, dir_d;
    logic [1:0] req_floor_q, req_floor_d;
    logic       req_active_q, req_active_d;
    logic       door_q, door_d;
    logic [2:0] pending_q, pending_d;

    logic [2:0] clr_mask;
    logic       tmr_load;
    logic       tmr_en;
    logic       tmr_done;

    logic [1:0] cur;
    logic       floor_ok;
    logic       parked;
    logic [2:0] here_oh;
    logic       arrived;
    logic       local_hit;
    logic       reopen;

    logic       up_found, dn_found;
    logic [1:0] up_tgt, dn_tgt;
    logic       sel_valid;
    logic [1:0] sel_floor;
    logic       sel_dir;

    assign cur       = bus.current_floor;
    assign floor_ok  = (cur != FLOOR_BAD);
    assign parked    = (bus.elevator_status == ST_IDLE);
    assign here_oh   = floor_onehot(cur);
    assign arrived   = floor_ok && parked && (cur == req_floor_q);
    assign local_hit = parked && (|(pending_q & here_oh));
    assign reopen    = |(bus.call_btn & here_oh);

    // Nearest pending floor above and below the current floor.
    always_comb begin
        up_found = 1'b0;
        up_tgt   = cur;
        dn_found = 1'b0;
        dn_tgt   = cur;
        unique case (cur)
            FLOOR_1: begin
                if (pending_q[1]) begin
                    up_found = 1'b1;
                    up_tgt   = FLOOR_2;
                end else if (pending_q[2]) begin
                    up_found = 1'b1;
                    up_tgt   = FLOOR_3;
                end
            end
            FLOOR_2: begin
                if (pending_q[2]) begin
                    up_found = 1'b1;
                    up_tgt   = FLOOR_3;
                end
                if (pending_q[0]) begin
                    dn_found = 1'b1;
                    dn_tgt   = FLOOR_1;
                end
            end
            FLOOR_3: begin
                if (pending_q[1]) begin
                    dn_found = 1'b1;
                    dn_tgt   = FLOOR_2;
                end else if (pending_q[0]) begin
                    dn_found = 1'b1;
                    dn_tgt   = FLOOR_1;
                end
            end
            default: begin
            end
        endcase
    end

    // SCAN choice: keep direction if possible, otherwise reverse.
    always_comb begin
        sel_valid = 1'b0;
        sel_floor = cur;
        sel_dir   = dir_q;
        if (dir_q == DIR_UP) begin
            if (up_found) begin
                sel_valid = 1'b1;
                sel_floor = up_tgt;
            end else if (dn_found) begin
                sel_valid = 1'b1;
                sel_floor = dn_tgt;
                sel_dir   = DIR_DOWN;
            end
        end else begin
            if (dn_found) begin
                sel_valid = 1'b1;
                sel_floor = dn_tgt;
            end else if (up_found) begin
                sel_valid = 1'b1;
                sel_floor = up_tgt;
                sel_dir   = DIR_UP;
            end
        end
    end

    // Scheduler FSM: park, dispatch and wait for arrival, then dwell.
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        req_floor_d  = req_floor_q;
        req_active_d = req_active_q;
        door_d       = door_q;
        clr_mask     = 3'b000;
        tmr_load     = 1'b0;
        tmr_en       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (floor_ok) begin
                    req_floor_d = cur;
                end
                if (local_hit) begin
                    clr_mask = here_oh;
                    door_d   = 1'b1;
                    tmr_load = 1'b1;
                    state_d  = DWELL;
                end else if (sel_valid) begin
                    dir_d        = sel_dir;
                    req_floor_d  = sel_floor;
                    req_active_d = 1'b1;
                    state_d      = DISPATCH;
                end
            end
            DISPATCH: begin
                if (arrived) begin
                    clr_mask     = floor_onehot(req_floor_q);
                    req_active_d = 1'b0;
                    door_d       = 1'b1;
                    tmr_load     = 1'b1;
                    state_d      = DWELL;
                end
            end
            DWELL: begin
                clr_mask = here_oh;
                if (reopen) begin
                    tmr_load = 1'b1;
                end else if (tmr_done) begin
                    door_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Latch new calls; drop the floor being served or dwelt on.
    assign pending_d = (pending_q | bus.call_btn) & ~clr_mask;

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            dir_q        <= DIR_UP;
            req_floor_q  <= FLOOR_1;
            req_active_q <= 1'b0;
            door_q       <= 1'b0;
            pending_q    <= 3'b000;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            req_floor_q  <= req_floor_d;
            req_active_q <= req_active_d;
            door_q       <= door_d;
            pending_q    <= pending_d;
        end
    end

    door_dwell_timer u_dwell (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (DWELL_LOAD),
        .en_i       (tmr_en),
        .done_o     (tmr_done)
    );

    assign bus.request_floor = req_floor_q;
    assign bus.req_active    = req_active_q;
    assign bus.pending       = pending_q;
    assign bus.door_open     = door_q;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Bench for elevator_request_scheduler: scripted calls, a stepping
// controller model, and scoreboards for dispatched floors and dwell lengths.
module tb_elevator_request_scheduler;
    import elevator_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    elevator_request_scheduler_if bus ();

    elevator_request_scheduler #(
        .DWELL_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [1:0] exp_req[$];
    int         exp_dwell[$];

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Controller model: one floor per cycle toward the request, then idle.
    task automatic travel();
        int g;
        g = 0;
        while (!bus.req_active && g < 20) begin
            tick();
            g++;
        end
        chk("trv_act", 8'(bus.req_active), 8'h1);
        g = 0;
        while (bus.current_floor != bus.request_floor && g < 4) begin
            if (bus.request_floor > bus.current_floor) begin
                bus.elevator_status = ST_UP;
                bus.current_floor   = bus.current_floor + 2'd1;
            end else begin
                bus.elevator_status = ST_DOWN;
                bus.current_floor   = bus.current_floor - 2'd1;
            end
            tick();
            g++;
        end
        bus.elevator_status = ST_IDLE;
    endtask

    task automatic wait_dwell();
        int g;
        g = 0;
        tick();
        while (bus.door_open && g < 300) begin
            tick();
            g++;
        end
        chk("dwell_end", 8'(bus.door_open), 8'h0);
    endtask

    // Scoreboard monitor: request floor on each new dispatch,
    // door-open pulse length on each falling edge.
    logic prev_act = 1'b0;
    int   run = 0;
    always @(negedge clk) begin
        if (bus.req_active && !prev_act) begin
            if (exp_req.size() == 0) begin
                chk("req_extra", 8'(bus.request_floor), 8'hff);
            end else begin
                chk("req_floor", 8'(bus.request_floor),
                    8'(exp_req.pop_front()));
            end
        end
        prev_act = bus.req_active;
        if (bus.door_open) begin
            run++;
        end else if (run != 0) begin
            if (exp_dwell.size() == 0) begin
                chk("dwell_extra", 8'(run), 8'h0);
            end else begin
                chk("dwell_len", 8'(run), 8'(exp_dwell.pop_front()));
            end
            run = 0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.call_btn        = 3'b000;
        bus.current_floor   = FLOOR_1;
        bus.elevator_status = ST_IDLE;
        tick();
        tick();
        chk("rst_req", 8'(bus.request_floor), 8'h0);
        chk("rst_act", 8'(bus.req_active), 8'h0);
        chk("rst_pend", 8'(bus.pending), 8'h0);
        chk("rst_door", 8'(bus.door_open), 8'h0);
        rst = 1'b0;
        tick();

        // Floor 1 -> call Floor 3.
        bus.call_btn = 3'b100;
        exp_req.push_back(FLOOR_3);
        exp_dwell.push_back(4);
        tick();
        bus.call_btn = 3'b000;
        chk("a_pend", 8'(bus.pending), 8'b100);
        chk("a_act0", 8'(bus.req_active), 8'h0);
        tick();
        chk("a_req", 8'(bus.request_floor), 8'h2);
        chk("a_act1", 8'(bus.req_active), 8'h1);
        travel();
        tick();
        chk("a_arr_pend", 8'(bus.pending), 8'h0);
        chk("a_arr_door", 8'(bus.door_open), 8'h1);
        chk("a_arr_act", 8'(bus.req_active), 8'h0);
        repeat (3) tick();
        chk("a_door_last", 8'(bus.door_open), 8'h1);
        tick();
        chk("a_door_off", 8'(bus.door_open), 8'h0);
        chk("a_req_hold", 8'(bus.request_floor), 8'h2);

        // Back down to Floor 1.
        bus.call_btn = 3'b001;
        exp_req.push_back(FLOOR_1);
        exp_dwell.push_back(4);
        tick();
        bus.call_btn = 3'b000;
        travel();
        wait_dwell();

        // Local call while parked: dwell only, no new request.
        bus.call_btn = 3'b001;
        exp_dwell.push_back(4);
        tick();
        bus.call_btn = 3'b000;
        tick();
        chk("c_req", 8'(bus.request_floor), 8'h0);
        chk("c_act", 8'(bus.req_active), 8'h0);
        chk("c_door", 8'(bus.door_open), 8'h1);
        chk("c_pend", 8'(bus.pending), 8'h0);
        wait_dwell();

        // Reset in the middle of a dispatch.
        bus.call_btn = 3'b110;
        exp_req.push_back(FLOOR_2);
        tick();
        bus.call_btn = 3'b000;
        tick();
        chk("d_act", 8'(bus.req_active), 8'h1);
        chk("d_req", 8'(bus.request_floor), 8'h1);
        chk("d_pend", 8'(bus.pending), 8'b110);
        rst = 1'b1;
        #1;
        chk("d_rst_pend", 8'(bus.pending), 8'h0);
        chk("d_rst_req", 8'(bus.request_floor), 8'h0);
        chk("d_rst_act", 8'(bus.req_active), 8'h0);
        chk("d_rst_door", 8'(bus.door_open), 8'h0);
        bus.current_floor = FLOOR_2;
        tick();
        rst = 1'b0;
        tick();

        // Floor 2, direction up, calls 1 and 3: sweep up then reverse.
        bus.call_btn = 3'b101;
        exp_req.push_back(FLOOR_3);
        exp_req.push_back(FLOOR_1);
        exp_dwell.push_back(4);
        exp_dwell.push_back(4);
        tick();
        bus.call_btn = 3'b000;
        chk("e_pend", 8'(bus.pending), 8'b101);
        tick();
        chk("e_req", 8'(bus.request_floor), 8'h2);
        travel();
        wait_dwell();
        chk("e_gap0", 8'(bus.req_active), 8'h0);
        tick();
        chk("e_gap1", 8'(bus.req_active), 8'h1);
        chk("e_rev", 8'(bus.request_floor), 8'h0);
        travel();
        wait_dwell();

        // Dwell at Floor 2 re-opened by a local call.
        bus.call_btn = 3'b010;
        exp_req.push_back(FLOOR_2);
        exp_dwell.push_back(6);
        tick();
        bus.call_btn = 3'b000;
        travel();
        tick();
        tick();
        bus.call_btn = 3'b010;
        tick();
        bus.call_btn = 3'b000;
        chk("f_pend", 8'(bus.pending), 8'h0);
        chk("f_door", 8'(bus.door_open), 8'h1);
        repeat (3) tick();
        chk("f_door_ext", 8'(bus.door_open), 8'h1);
        tick();
        chk("f_door_off", 8'(bus.door_open), 8'h0);

        repeat (4) tick();
        chk("f_idle", 8'(bus.req_active), 8'h0);
        chk("sb_req_left", 8'(exp_req.size()), 8'h0);
        chk("sb_dwell_left", 8'(exp_dwell.size()), 8'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
